// File: rtl/trace_renderer.sv
// Two-channel trace renderer: snapshots ch1/ch2 at the start of vblank and draws
// them as joined traces on 640x480@60 VGA. Define GRATICULE_EN to add a grid.
module trace_renderer #(
  parameter logic [11:0] CH1_COLOR = 12'hFF0,
  parameter logic [11:0] CH2_COLOR = 12'h0FF,
  parameter logic [11:0] BG_COLOR  = 12'h000
) (
  input  logic             clk_100MHz,
  input  logic             rst,
  input  logic [639:0][9:0] ch1,
  input  logic [639:0][9:0] ch2,
  output logic             hsync,
  output logic             vsync,
  output logic [3:0]       vga_r,
  output logic [3:0]       vga_g,
  output logic [3:0]       vga_b,
  output logic             frame_start
);

  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_SYNC_START = 10'd656;
  localparam logic [9:0] H_SYNC_END   = 10'd751;
  localparam logic [9:0] H_LAST       = 10'd799;
  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_SYNC_START = 10'd490;
  localparam logic [9:0] V_SYNC_END   = 10'd491;
  localparam logic [9:0] V_LAST       = 10'd524;
  localparam logic [8:0] ROW_MAX      = 9'd479;
`ifdef GRATICULE_EN
  localparam logic [11:0] GRID_COLOR  = 12'h444;
`endif

  logic [1:0]  div;
  logic        tick;
  logic [9:0]  hc;
  logic [9:0]  vc;
  logic        snap_tick;
  logic [8:0]  s1 [640];
  logic [8:0]  s2 [640];
  logic [11:0] rgb;

  assign tick      = (div == 2'd3);
  assign snap_tick = tick && (hc == 10'd0) && (vc == V_VISIBLE);
  // Reset must suppress the pulse when it lands on the snapshot tick.
  assign frame_start = snap_tick && !rst;

  always_ff @(posedge clk_100MHz) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      div <= 2'd0;
      hc  <= 10'd0;
      vc  <= 10'd0;
    end else begin
      div <= div + 2'd1;
      if (tick) begin
        if (hc == H_LAST) begin
          hc <= 10'd0;
          vc <= (vc == V_LAST) ? 10'd0 : vc + 10'd1;
        end else begin
          hc <= hc + 10'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_100MHz) begin
    // NOTE: the snapshot arrays are reset too, so the first frame draws from known rows.
    if (rst) begin
      for (int i = 0; i < 640; i++) begin
        s1[i] <= ROW_MAX;
        s2[i] <= ROW_MAX;
      end
    end else if (snap_tick) begin
      for (int i = 0; i < 640; i++) begin
        s1[i] <= (ch1[i] > {1'b0, ROW_MAX}) ? ROW_MAX : ch1[i][8:0];
        s2[i] <= (ch2[i] > {1'b0, ROW_MAX}) ? ROW_MAX : ch2[i][8:0];
      end
    end
  end

  function automatic logic seg_hit(input logic [9:0] a, input logic [9:0] b,
                                   input logic [9:0] y);
    return (a <= b) ? (y >= a && y <= b) : (y >= b && y <= a);
  endfunction

  logic       visible;
  logic [9:0] col;
  logic [9:0] prev_col;
  logic       ch1_hit;
  logic       ch2_hit;
  logic [11:0] pix;

  assign visible  = (hc < H_VISIBLE) && (vc < V_VISIBLE);
  // Column 0 pairs with itself, so its segment degenerates to a single row.
  assign col      = (hc < H_VISIBLE) ? hc : 10'd0;
  assign prev_col = (col == 10'd0) ? 10'd0 : col - 10'd1;
  assign ch1_hit  = seg_hit({1'b0, s1[col]}, {1'b0, s1[prev_col]}, vc);
  assign ch2_hit  = seg_hit({1'b0, s2[col]}, {1'b0, s2[prev_col]}, vc);

  always_comb begin
    // NOTE: default assigned first so every path drives pix and no latch is inferred.
    pix = BG_COLOR;
`ifdef GRATICULE_EN
    if (hc[5:0] == 6'd0 || (vc % 10'd60) == 10'd0 || hc == 10'd639 || vc == 10'd479)
      pix = GRID_COLOR;
`endif
    if (ch2_hit) pix = CH2_COLOR;
    if (ch1_hit) pix = CH1_COLOR;
    if (!visible) pix = 12'h000;
  end

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      rgb   <= 12'h000;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (tick) begin
      rgb   <= pix;
      hsync <= !(hc >= H_SYNC_START && hc <= H_SYNC_END);
      vsync <= !(vc >= V_SYNC_START && vc <= V_SYNC_END);
    end
  end

  assign vga_r = rgb[11:8];
  assign vga_g = rgb[7:4];
  assign vga_b = rgb[3:0];

endmodule
